// File: rtl/usb_tx_encoder.sv
// Full-speed USB 1.1 transmit line encoder: SYNC, LSB-first data with bit stuffing
// and NRZI, then EOP, driven onto registered D+/D- lines.
module usb_tx_encoder #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [2:0]    ones_cnt, ones_cnt_n;
    logic [7:0]    hold_reg, hold_reg_n;
    logic          hold_full, hold_full_n;
    logic [7:0]    shift_reg, shift_reg_n;
    logic          dp, dp_n, dm, dm_n;
    logic          busy, busy_n, done, done_n;
    logic          handshake, boundary, send, bit_v, byte_end;

    assign tx_ready   = !hold_full && !(state inside {EOP_SE0, EOP_J});
    assign handshake  = tx_valid && tx_ready;
    assign boundary   = (timer == T_LAST);
    assign dplus_out  = dp;
    assign dminus_out = dm;
    assign tx_busy    = busy;
    assign tx_done    = done;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            ones_cnt  <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            shift_reg <= '0;
            dp        <= 1'b1;
            dm        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            bit_idx   <= bit_idx_n;
            ones_cnt  <= ones_cnt_n;
            hold_reg  <= hold_reg_n;
            hold_full <= hold_full_n;
            shift_reg <= shift_reg_n;
            dp        <= dp_n;
            dm        <= dm_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        bit_idx_n   = bit_idx;
        ones_cnt_n  = ones_cnt;
        hold_reg_n  = hold_reg;
        hold_full_n = hold_full;
        shift_reg_n = shift_reg;
        dp_n        = dp;
        dm_n        = dm;
        busy_n      = busy;
        done_n      = 1'b0;
        send        = 1'b0;
        bit_v       = 1'b0;
        byte_end    = 1'b0;

        if (handshake) begin
            hold_reg_n  = tx_data;
            hold_full_n = 1'b1;
        end
        if (state != IDLE)
            timer_n = boundary ? '0 : timer + TW'(1);

        case (state)
            IDLE: begin
                if (handshake) begin
                    state_n   = SYNC;
                    busy_n    = 1'b1;
                    bit_idx_n = '0;
                    send      = 1'b1;
                end
            end
            SYNC, DATA: begin
                if (boundary) begin
                    if (ones_cnt == 3'd6) begin
                        state_n = STUFF;
                        send    = 1'b1;
                    end else if (bit_idx == 3'd7) begin
                        byte_end = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        send      = 1'b1;
                        if (state == SYNC) begin
                            bit_v = (bit_idx == 3'd6);
                        end else begin
                            bit_v       = shift_reg[1];
                            shift_reg_n = shift_reg >> 1;
                        end
                    end
                end
            end
            STUFF: begin
                // bit_idx still points at the last data bit sent, so resume from it
                if (boundary) begin
                    if (bit_idx == 3'd7) begin
                        byte_end = 1'b1;
                    end else begin
                        state_n     = DATA;
                        bit_idx_n   = bit_idx + 3'd1;
                        send        = 1'b1;
                        bit_v       = shift_reg[1];
                        shift_reg_n = shift_reg >> 1;
                    end
                end
            end
            EOP_SE0: begin
                if (boundary) begin
                    if (bit_idx == 3'd1) begin
                        state_n = EOP_J;
                        dp_n    = 1'b1;
                        dm_n    = 1'b0;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            EOP_J: begin
                if (boundary) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (byte_end) begin
            bit_idx_n = '0;
            if (hold_full) begin
                state_n     = DATA;
                shift_reg_n = hold_reg;
                hold_full_n = 1'b0;
                send        = 1'b1;
                bit_v       = hold_reg[0];
            end else begin
                state_n = EOP_SE0;
                dp_n    = 1'b0;
                dm_n    = 1'b0;
            end
        end

        // NRZI: a 0 toggles the lines and breaks the run of ones
        if (send) begin
            if (!bit_v) begin
                dp_n       = ~dp;
                dm_n       = ~dm;
                ones_cnt_n = '0;
            end else begin
                ones_cnt_n = ones_cnt + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: line waveforms per bit, handshake timing,
// tx_done placement and mid-packet reset.
module tb_usb_tx_encoder;
    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, dplus_out, dminus_out, tx_busy, tx_done;
    int         total = 0;
    int         bad   = 0;

    usb_tx_encoder #(.CLKS_PER_BIT(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .dplus_out  (dplus_out),
        .dminus_out (dminus_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] sym(input byte c);
        if (c == "J") return 2'b10;
        if (c == "K") return 2'b01;
        return 2'b00;
    endfunction

    // Starts at a negedge with the DUT ready; returns at the negedge of the tx_done
    // cycle, or of the cycle after reset when rst_cyc is nonzero.
    task automatic run_pkt(input logic [7:0] b0, input string exp, input logic [7:0] b1,
                           input int unsigned wr_cyc, input int unsigned rst_cyc);
        int unsigned len;
        len = exp.len();
        tx_data  = b0;
        tx_valid = 1'b1;
        chk("ready_at_start", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        for (int unsigned cyc = 1; cyc <= len * 8 + 1; cyc++) begin
            if (cyc <= len * 8) begin
                if (((cyc - 1) % 8 == 0) || ((cyc - 1) % 8 == 7))
                    chk($sformatf("line_bit%0d", (cyc - 1) / 8), {dplus_out, dminus_out},
                        sym(exp[(cyc - 1) / 8]));
            end else begin
                chk("done_pulse", tx_done, 1);
                chk("busy_end", tx_busy, 0);
                chk("line_idle_j", {dplus_out, dminus_out}, 2'b10);
            end
            if (cyc == len * 8) chk("done_early", tx_done, 0);
            if (cyc == 1) begin
                chk("busy_start", tx_busy, 1);
                chk("ready_held", tx_ready, 0);
                chk("done_clear", tx_done, 0);
            end
            if (cyc == 64) chk("ready_sync_end", tx_ready, 0);
            if (cyc == 65) chk("ready_load1", tx_ready, 1);
            if (wr_cyc != 0) begin
                if (cyc == wr_cyc) begin
                    chk("ready_before_wr", tx_ready, 1);
                    tx_data  = b1;
                    tx_valid = 1'b1;
                end
                if (cyc == wr_cyc + 1) begin
                    chk("ready_after_wr", tx_ready, 0);
                    tx_valid = 1'b0;
                end
                if (cyc == 128) chk("ready_byte1_end", tx_ready, 0);
                if (cyc == 129) chk("ready_load2", tx_ready, 1);
            end
            if (rst_cyc != 0 && cyc == rst_cyc) begin
                n_rst = 1'b0;
                @(negedge clk);
                n_rst = 1'b1;
                chk("rst_line_j", {dplus_out, dminus_out}, 2'b10);
                chk("rst_busy", tx_busy, 0);
                chk("rst_done", tx_done, 0);
                chk("rst_ready", tx_ready, 1);
                return;
            end
            if (cyc <= len * 8) @(negedge clk);
        end
    endtask

    initial begin
        logic seen_done, seen_nonj;
        n_rst    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (2) @(negedge clk);
        chk("reset_lines", {dplus_out, dminus_out}, 2'b10);
        chk("reset_ready", tx_ready, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_done", tx_done, 0);
        n_rst = 1'b1;
        @(negedge clk);

        run_pkt(8'h00, "KJKJKJKKJKJKJKJK00J", 8'h00, 0, 0);
        run_pkt(8'hFF, "KJKJKJKKKKKKKJJJJ00J", 8'h00, 0, 0);
        run_pkt(8'hFC, "KJKJKJKKJKKKKKKKJ00J", 8'h00, 0, 0);
        run_pkt(8'hA5, "KJKJKJKKKJJKJJKKJKKKKKJK00J", 8'h3C, 70, 0);
        run_pkt(8'hA5, "KJKJKJKKKJJKJJKKJKKKKKJK00J", 8'h3C, 70, 83);

        seen_done = 1'b0;
        seen_nonj = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (tx_done) seen_done = 1'b1;
            if ({dplus_out, dminus_out} != 2'b10) seen_nonj = 1'b1;
        end
        chk("post_rst_no_done", seen_done, 0);
        chk("post_rst_no_eop", seen_nonj, 0);

        run_pkt(8'h00, "KJKJKJKKJKJKJKJK00J", 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
